// File: rtl/descrambler_rx_9.sv
// descrambler_rx_9: 127-bit Galois LFSR descrambler, 16 steps per word.
// Ports: clk/rst (async high); write/addr/lfsrdin seed writes at 0x0d0..0x0d3;
//   in_valid/in_data scrambled words in; out_valid/out_data registered result;
//   running, zero_seed, collision (sticky), word_cnt (saturating) status.
module descrambler_rx_9 #(
  parameter int POLY_WIDTH   = 127,
  parameter int NUM_OF_STEPS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic [11:0] addr,
  input  logic [31:0] lfsrdin,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        running,
  output logic        zero_seed,
  output logic        collision,
  output logic [15:0] word_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [POLY_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [3:0]              mask_q, mask_d;
  logic                    out_valid_q, out_valid_d;
  logic [15:0]             out_data_q, out_data_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    zero_q, zero_d;
  logic                    coll_q, coll_d;

  logic                    seed_hit;
  logic [1:0]              widx;
  logic [3:0]              wsel;
  logic                    active;
  logic                    accept;
  logic [15:0]             ks;

  function automatic logic [POLY_WIDTH-1:0] step(
    input logic [POLY_WIDTH-1:0] s
  );
    logic                  f;
    logic [POLY_WIDTH-1:0] n;
    f     = s[POLY_WIDTH-1];
    n     = {s[POLY_WIDTH-2:0], f};
    n[13] = s[12] ^ f;
    n[45] = s[44] ^ f;
    n[54] = s[53] ^ f;
    return n;
  endfunction

  function automatic logic [POLY_WIDTH-1:0] advance(
    input logic [POLY_WIDTH-1:0] s
  );
    logic [POLY_WIDTH-1:0] t;
    t = s;
    for (int i = 0; i < NUM_OF_STEPS; i++) begin
      t = step(t);
    end
    return t;
  endfunction

  // Seed window is the aligned 4-word block at 0x0d0.
  assign seed_hit = write && (addr[11:2] == 10'h034);
  assign widx     = addr[1:0];
  assign wsel     = 4'b0001 << widx;
  assign active   = (state_q != IDLE);
  // A simultaneous seed write always wins over the data word.
  assign accept   = in_valid && !seed_hit && active;
  assign ks       = lfsr_q[POLY_WIDTH-1 -: 16];

  always_comb begin
    lfsr_d      = lfsr_q;
    mask_d      = mask_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    coll_d      = coll_q;
    if (seed_hit) begin
      unique case (widx)
        2'd0: lfsr_d[31:0]   = lfsrdin;
        2'd1: lfsr_d[63:32]  = lfsrdin;
        2'd2: lfsr_d[95:64]  = lfsrdin;
        2'd3: lfsr_d[126:96] = lfsrdin[30:0];
        default: ;
      endcase
      if (active) begin
        mask_d = wsel;
        cnt_d  = '0;
        if (in_valid) coll_d = 1'b1;
      end else begin
        mask_d = mask_q | wsel;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ ks;
      lfsr_d      = advance(lfsr_q);
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (seed_hit && (mask_d == 4'hF) && (lfsr_d != '0))
          state_d = ARMED;
      end
      ARMED, RUN: begin
        if (seed_hit)      state_d = IDLE;
        else if (in_valid) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Full mask but all-zero seed parks in IDLE with the flag raised.
  assign zero_d = (state_d == IDLE) && (mask_d == 4'hF) &&
                  (lfsr_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      coll_q      <= coll_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign running   = (state_q == RUN);
  assign zero_seed = zero_q;
  assign collision = coll_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_descrambler_rx_9.sv
// tb_descrambler_rx_9: directed + random bench for descrambler_rx_9.
// Reference keystream is a polynomial-multiply-by-x model of the LFSR.
module tb_descrambler_rx_9;

  logic        clk;
  logic        rst;
  logic        write;
  logic [11:0] addr;
  logic [31:0] lfsrdin;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        running;
  logic        zero_seed;
  logic        collision;
  logic [15:0] word_cnt;

  int n_assert;
  int n_fail;

  logic [126:0] m_state;
  logic [126:0] tx;
  logic [15:0]  d;
  logic [15:0]  exp_d;

  localparam logic [126:0] TAPS =
    (127'd1) | (127'd1 << 13) | (127'd1 << 45) | (127'd1 << 54);

  descrambler_rx_9 dut (
    .clk       (clk),
    .rst       (rst),
    .write     (write),
    .addr      (addr),
    .lfsrdin   (lfsrdin),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .running   (running),
    .zero_seed (zero_seed),
    .collision (collision),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiply by x modulo the feedback polynomial, 16 times.
  function automatic logic [126:0] m_adv(input logic [126:0] s);
    logic         fb;
    logic [126:0] t;
    t = s;
    for (int i = 0; i < 16; i++) begin
      fb = t[126];
      t  = t << 1;
      if (fb) t = t ^ TAPS;
    end
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic seed(input int w, input logic [31:0] v);
    write   = 1'b1;
    addr    = 12'h0d0 + 12'(w);
    lfsrdin = v;
    case (w)
      0: m_state[31:0]   = v;
      1: m_state[63:32]  = v;
      2: m_state[95:64]  = v;
      default: m_state[126:96] = v[30:0];
    endcase
    cyc();
    write = 1'b0;
  endtask

  task automatic rx_word(input string tag, input logic [15:0] v);
    logic [15:0] e;
    e        = v ^ m_state[126:111];
    m_state  = m_adv(m_state);
    in_valid = 1'b1;
    in_data  = v;
    cyc();
    in_valid = 1'b0;
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(e));
  endtask

  task automatic send(input logic [15:0] v, input bit chk);
    in_data  = v ^ tx[126:111];
    tx       = m_adv(tx);
    m_state  = m_adv(m_state);
    in_valid = 1'b1;
    cyc();
    if (chk) begin
      check("loop_vld", 32'(out_valid), 32'd1);
      check("loop_data", 32'(out_data), 32'(v));
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m_state  = '0;
    rst      = 1'b1;
    write    = 1'b0;
    addr     = '0;
    lfsrdin  = '0;
    in_valid = 1'b0;
    in_data  = '0;
    cyc();
    cyc();
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_run", 32'(running), 32'd0);
    check("rst_zero", 32'(zero_seed), 32'd0);
    check("rst_coll", 32'(collision), 32'd0);
    check("rst_cnt", 32'(word_cnt), 32'd0);
    rst = 1'b0;

    // Known-answer word
    seed(0, 32'h0);
    seed(1, 32'h0);
    seed(2, 32'h0);
    seed(3, 32'h4000_0000);
    cyc();
    check("ka_run0", 32'(running), 32'd0);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    cyc();
    in_valid = 1'b0;
    check("ka_vld", 32'(out_valid), 32'd1);
    check("ka_data", 32'(out_data), 32'h9234);
    check("ka_run", 32'(running), 32'd1);
    check("ka_cnt", 32'(word_cnt), 32'd1);
    m_state = m_adv(m_state);
    cyc();
    check("ka_idle_vld", 32'(out_valid), 32'd0);
    check("ka_hold", 32'(out_data), 32'h9234);

    // All-zero seed
    for (int w = 0; w < 4; w++) seed(w, 32'h0);
    check("zs_flag", 32'(zero_seed), 32'd1);
    check("zs_run", 32'(running), 32'd0);
    check("zs_cnt", 32'(word_cnt), 32'd0);
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    cyc();
    in_valid = 1'b0;
    check("zs_novld", 32'(out_valid), 32'd0);
    check("zs_cnt2", 32'(word_cnt), 32'd0);
    seed(0, 32'h1);
    check("zs_clear", 32'(zero_seed), 32'd0);
    rx_word("zs_w0", 16'hA5C3);
    check("zs_run2", 32'(running), 32'd1);
    // Unmapped address has no effect
    write   = 1'b1;
    addr    = 12'h0d4;
    lfsrdin = 32'hFFFF_FFFF;
    cyc();
    write = 1'b0;
    check("oth_run", 32'(running), 32'd1);
    for (int i = 0; i < 12; i++) rx_word("oth_w", 16'($urandom));
    check("oth_cnt", 32'(word_cnt), 32'd13);

    // Loopback against an identically seeded transmitter
    rst = 1'b1;
    cyc();
    rst     = 1'b0;
    m_state = '0;
    seed(0, $urandom | 32'h1);
    seed(1, $urandom);
    seed(2, $urandom);
    seed(3, $urandom);
    tx = m_state;
    for (int i = 0; i < 1000; i++) send(16'($urandom), 1'b1);
    in_valid = 1'b0;
    check("loop_cnt", 32'(word_cnt), 32'd1000);

    // Saturation of the word counter
    for (int i = 1000; i < 65535; i++) send(16'($urandom), 1'b0);
    check("sat_cnt", 32'(word_cnt), 32'hFFFF);
    for (int i = 0; i < 3; i++) send(16'($urandom), 1'b1);
    in_valid = 1'b0;
    check("sat_hold", 32'(word_cnt), 32'hFFFF);

    // Seed write colliding with data in RUN
    in_valid = 1'b1;
    in_data  = 16'h5555;
    seed(1, 32'h0);
    in_valid = 1'b0;
    check("col_vld", 32'(out_valid), 32'd0);
    check("col_flag", 32'(collision), 32'd1);
    check("col_run", 32'(running), 32'd0);
    check("col_cnt", 32'(word_cnt), 32'd0);

    // Reset during back-to-back traffic
    seed(0, $urandom | 32'h1);
    seed(1, $urandom);
    seed(2, $urandom);
    seed(3, $urandom);
    tx = m_state;
    for (int i = 0; i < 5; i++) send(16'($urandom), 1'b1);
    #3 rst = 1'b1;
    #1;
    check("mr_vld", 32'(out_valid), 32'd0);
    check("mr_data", 32'(out_data), 32'd0);
    check("mr_run", 32'(running), 32'd0);
    check("mr_coll", 32'(collision), 32'd0);
    check("mr_cnt", 32'(word_cnt), 32'd0);
    cyc();
    rst     = 1'b0;
    m_state = '0;
    cyc();
    check("pr_vld", 32'(out_valid), 32'd0);
    cyc();
    check("pr_vld2", 32'(out_valid), 32'd0);
    check("pr_cnt", 32'(word_cnt), 32'd0);
    seed(0, $urandom | 32'h1);
    seed(1, $urandom);
    seed(2, $urandom);
    check("pr_coll", 32'(collision), 32'd0);
    cyc();
    check("pr_part", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    seed(3, $urandom);
    d = 16'($urandom);
    exp_d = d ^ m_state[126:111];
    rx_word("pr_w", d);
    check("pr_cnt1", 32'(word_cnt), 32'd1);
    check("pr_ks", 32'(out_data ^ d), 32'(exp_d ^ d));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
